// File: rtl/alu_if.sv
// Operation request/response bundle between a controller and alu_unit.
interface alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             done;
    logic             busy;

    modport master (
        output start, alu_ctrl, a, b,
        input  result, zero, done, busy
    );

    modport slave (
        input  start, alu_ctrl, a, b,
        output result, zero, done, busy
    );
endinterface

// File: rtl/alu_unit.sv
// Single-cycle AND/OR/ADD/SUB plus a WIDTH-cycle shift-add multiplier.
module alu_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_sum;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    case (bus.alu_ctrl)
                        4'b0000: result_d = bus.a & bus.b;
                        4'b0001: result_d = bus.a | bus.b;
                        4'b0010: result_d = bus.a + bus.b;
                        4'b0011: result_d = bus.a - bus.b;
                        4'b0100: begin
                            done_d   = 1'b0;
                            mcand_d  = bus.a;
                            mplier_d = bus.b;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = StMul;
                        end
                        default: result_d = '0;
                    endcase
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                // Final iteration: the sum just formed is the full product.
                if (cnt_q == LastIter) begin
                    result_d = acc_sum;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = (result_q == '0);
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == StMul);
endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit with a result scoreboard queue.
module tb_alu_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    logic [W-1:0] exp_q[$];

    alu_if #(.WIDTH(W)) bus ();

    alu_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        reset        = 1'b0;
        bus.start    = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.a        = av;
        bus.b        = bv;
    endtask

    // Drives one op, waits for done, checks latency, busy span and scoreboard result.
    // inject: pulse an ADD with new operands mid-MUL, which must be ignored.
    task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp_v, input int lat,
                          input bit inject);
        int n;
        int busy_n;
        logic [W-1:0] e;
        issue(ctrl, av, bv);
        exp_q.push_back(exp_v);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && n < lat + 5) begin
            if (bus.busy === 1'b1) busy_n++;
            if (inject && n == 5) begin
                bus.start    = 1'b1;
                bus.alu_ctrl = 4'b0010;
                bus.a        = 32'h1111;
                bus.b        = 32'h2222;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_cycles"}, busy_n, lat - 1);
        check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
        e = exp_q.pop_front();
        check({tag, "_result"}, bus.result, e);
        check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, (e == '0)});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_hold"}, bus.result, e);
    endtask

    initial begin
        logic [W-1:0] e;
        bus.start    = 1'b0;
        bus.alu_ctrl = 4'b0000;
        bus.a        = '0;
        bus.b        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", {31'b0, bus.zero}, 32'd1);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);

        // Reset released on the same edge that samples start.
        run_op("add", 4'b0010, 32'd5, 32'd7, 32'd12, 1, 1'b0);
        run_op("sub_eq", 4'b0011, 32'd9, 32'd9, 32'd0, 1, 1'b0);
        run_op("sub_wrap", 4'b0011, 32'd0, 32'd1, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("or", 4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1, 1'b0);
        run_op("add_carry", 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, 1'b0);
        run_op("mul", 4'b0100, 32'd7, 32'd6, 32'd42, W + 1, 1'b1);
        run_op("mul_wrap", 4'b0100, 32'h0001_0000, 32'h0001_0000, 32'd0, W + 1, 1'b0);
        run_op("mul_big", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, W + 1, 1'b0);
        run_op("illegal", 4'b1111, 32'd3, 32'd4, 32'd0, 1, 1'b0);

        // Abort a MUL with reset after 10 busy cycles.
        run_op("pre_abort", 4'b0010, 32'd1, 32'd2, 32'd3, 1, 1'b0);
        issue(4'b0100, 32'd100, 32'd100);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", bus.result, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        repeat (W + 2) begin
            @(negedge clk);
            if (bus.done !== 1'b0) check("abort_no_done", {31'b0, bus.done}, 32'd0);
        end
        check("abort_idle_result", bus.result, 32'd0);
        run_op("and", 4'b0000, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1, 1'b0);

        // Back-to-back single-cycle ops with start held high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                check("b2b_done", {31'b0, bus.done}, 32'd1);
                check("b2b_result", bus.result, e);
            end
            if (i < 3) begin
                bus.start    = 1'b1;
                bus.alu_ctrl = 4'b0010;
                bus.a        = 32'd10 * i;
                bus.b        = 32'd3;
                exp_q.push_back(32'd10 * i + 32'd3);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_done_end", {31'b0, bus.done}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
